// File: rtl/fetch_dispatch_ctrl.sv
// Instruction fetch/dispatch controller: fetches one word per step, dispatches it to the executing unit, waits for done.
// Optional single-step mode (stepReq input, STEPWAIT state) is built when SINGLE_STEP_EN is defined.
module fetch_dispatch_ctrl #(
    parameter int          MEM_LAT     = 2,
    parameter int          WDOG_CYCLES = 64,
    parameter logic [15:0] BUBBLE      = 16'hE000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memData,
    input  logic        done,
`ifdef SINGLE_STEP_EN
    input  logic        stepReq,
`endif
    output logic        pcOutEN,
    output logic        memRdEN,
    output logic        irLatch,
    output logic [15:0] instruction,
    output logic [3:0]  unitSel,
    output logic        pcInc,
    output logic        busy,
    output logic        illegalOp,
    output logic        wdogErr,
    output logic        halted
);

    localparam logic [3:0] LAT_INIT  = 4'(MEM_LAT - 1);
    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, RETIRE, SKIP, HALT, STEPWAIT
    } state_t;

    state_t      state, next;
    logic [15:0] ir;
    logic [3:0]  lat_cnt;
    logic [7:0]  wdog;
    logic        illegal_q;
    logic        wdog_err_q;

    // Legal opcodes come in pairs; each pair maps to one execution unit.
    function automatic logic [3:0] unit_of(input logic [3:0] op);
        case (op[3:1])
            3'd0:    unit_of = 4'b1000;
            3'd1:    unit_of = 4'b0100;
            3'd2:    unit_of = 4'b0010;
            3'd3:    unit_of = 4'b0001;
            default: unit_of = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir         <= BUBBLE;
            lat_cnt    <= '0;
            wdog       <= '0;
            illegal_q  <= 1'b0;
            wdog_err_q <= 1'b0;
        end else begin
            // Latency counter is preloaded in every non-FETCH state so each fetch starts fresh.
            if (state != FETCH)      lat_cnt <= LAT_INIT;
            else if (lat_cnt != '0)  lat_cnt <= lat_cnt - 4'd1;
            if (state == FETCH && lat_cnt == '0) ir <= memData;
            wdog <= (state == EXEC) ? wdog + 8'd1 : 8'd0;
            if (state == SKIP) illegal_q <= 1'b1;
            if (state == EXEC && !done && wdog == WDOG_LAST) wdog_err_q <= 1'b1;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:   next = FETCH;
            FETCH:  if (lat_cnt == '0) next = DECODE;
            DECODE: begin
                if (!ir[15])                next = EXEC;
                else if (ir[15:12] == 4'hF) next = HALT;
                else                        next = SKIP;
            end
            EXEC: begin
                if (done)                    next = RETIRE;
                else if (wdog == WDOG_LAST)  next = HALT;
            end
`ifdef SINGLE_STEP_EN
            RETIRE, SKIP: next = STEPWAIT;
            STEPWAIT:     if (stepReq) next = FETCH;
`else
            RETIRE, SKIP: next = FETCH;
            STEPWAIT:     next = IDLE;
`endif
            HALT:    next = HALT;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        pcOutEN     = (state == FETCH);
        memRdEN     = (state == FETCH);
        irLatch     = (state == FETCH) && (lat_cnt == '0);
        instruction = (state == EXEC) ? ir : BUBBLE;
        unitSel     = (state == EXEC) ? unit_of(ir[15:12]) : 4'b0000;
        pcInc       = (state == SKIP);
        busy        = !(state == IDLE || state == HALT || state == STEPWAIT);
        halted      = (state == HALT);
        illegalOp   = illegal_q;
        wdogErr     = wdog_err_q;
    end

endmodule

// File: tb/tb_fetch_dispatch_ctrl.sv
// Scoreboard bench for fetch_dispatch_ctrl: a per-cycle schedule is built from the instruction-level timing rules,
// driven one entry per cycle, and a monitor compares every DUT output against the queued expectation.
module tb_fetch_dispatch_ctrl;

    localparam int          MEM_LAT = 2;
    localparam int          WD      = 64;
    localparam logic [15:0] BUB     = 16'hE000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] memData = '0;
    logic        done = 1'b0;
`ifdef SINGLE_STEP_EN
    logic        stepReq = 1'b0;
    int          sw_first = 20;
`endif
    logic        pcOutEN, memRdEN, irLatch, pcInc, busy, illegalOp, wdogErr, halted;
    logic [15:0] instruction;
    logic [3:0]  unitSel;

    fetch_dispatch_ctrl #(.MEM_LAT(MEM_LAT), .WDOG_CYCLES(WD), .BUBBLE(BUB)) dut (
        .clk(clk), .rst(rst), .memData(memData), .done(done),
`ifdef SINGLE_STEP_EN
        .stepReq(stepReq),
`endif
        .pcOutEN(pcOutEN), .memRdEN(memRdEN), .irLatch(irLatch), .instruction(instruction),
        .unitSel(unitSel), .pcInc(pcInc), .busy(busy), .illegalOp(illegalOp),
        .wdogErr(wdogErr), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mem;
        logic        dn, rs, st, chk;
        logic        fe, irl;
        logic [15:0] ins;
        logic [3:0]  us;
        logic        pci, bsy, ill, wd, hlt;
    } ent_t;

    ent_t sched[$];
    ent_t expq[$];
    bit   ill_m = 1'b0, wd_m = 1'b0;
    int   checks = 0, errors = 0, cyc = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(logic [15:0] mem, logic dn, logic fe, logic irl, logic [15:0] ins,
                                logic [3:0] us, logic pci, logic bsy, logic hlt);
        ent_t e;
        e.mem = mem; e.dn = dn; e.rs = 1'b0; e.st = 1'b0; e.chk = 1'b1;
        e.fe = fe; e.irl = irl; e.ins = ins; e.us = us; e.pci = pci; e.bsy = bsy;
        e.ill = ill_m; e.wd = wd_m; e.hlt = hlt;
        sched.push_back(e);
    endfunction

    // Reset is sampled at the end of the last scheduled cycle; the next cycle is IDLE with flags cleared.
    function automatic void do_rst();
        sched[sched.size()-1].rs = 1'b1;
        ill_m = 1'b0; wd_m = 1'b0;
        add(16'($urandom), rb(), 0, 0, BUB, 4'd0, 0, 0, 0);
    endfunction

    function automatic void fetch(logic [15:0] w, int upto);
        for (int i = 0; i < upto; i++)
            add((i == MEM_LAT-1) ? w : 16'($urandom), rb(), 1, (i == MEM_LAT-1), BUB, 4'd0, 0, 1, 0);
    endfunction

    function automatic void stepwait();
`ifdef SINGLE_STEP_EN
        int n;
        n = (sw_first > 0) ? sw_first : $urandom_range(0, 5);
        sw_first = 0;
        for (int i = 0; i <= n; i++) begin
            add(16'($urandom), rb(), 0, 0, BUB, 4'd0, 0, 0, 0);
            sched[sched.size()-1].st = (i == n);
        end
`endif
    endfunction

    function automatic void halt_hold(int h);
        for (int i = 0; i < h; i++) add(16'($urandom), rb(), 0, 0, BUB, 4'd0, 0, 0, 1);
        do_rst();
    endfunction

    // One instruction: n = EXEC cycles until done (n > WD means done never comes),
    // rst_at > 0 applies reset during that EXEC cycle instead.
    function automatic void instr(logic [15:0] w, int n, int rst_at, int hold);
        logic [3:0] us;
        fetch(w, MEM_LAT);
        add(16'($urandom), rb(), 0, 0, BUB, 4'd0, 0, 1, 0);
        if (w[15] == 1'b0) begin
            us = 4'b1000 >> w[14:13];
            if (rst_at > 0) begin
                for (int k = 1; k <= rst_at; k++) add(16'($urandom), 0, 0, 0, w, us, 0, 1, 0);
                do_rst();
                sched[sched.size()-1].dn = 1'b1;
            end else if (n <= WD) begin
                for (int k = 1; k <= n; k++) add(16'($urandom), (k == n), 0, 0, w, us, 0, 1, 0);
                add(16'($urandom), rb(), 0, 0, BUB, 4'd0, 0, 1, 0);
                stepwait();
            end else begin
                for (int k = 1; k <= WD; k++) add(16'($urandom), 0, 0, 0, w, us, 0, 1, 0);
                wd_m = 1'b1;
                halt_hold(hold);
            end
        end else if (w[15:12] == 4'hF) begin
            halt_hold(hold);
        end else begin
            add(16'($urandom), rb(), 0, 0, BUB, 4'd0, 1, 1, 0);
            ill_m = 1'b1;
            stepwait();
        end
    endfunction

    function automatic void build();
        ent_t e;
        int   r;
        logic [15:0] w;
        for (int i = 0; i < 3; i++) begin
            add(16'h0, 0, 0, 0, BUB, 4'd0, 0, 0, 0);
            sched[sched.size()-1].chk = 1'b0;
        end
        do_rst();
        instr(16'h0042, 9, 0, 0);
        instr(16'h9000, 0, 0, 0);
        instr(16'hE000, 0, 0, 0);
        instr(16'h2345, WD + 1, 0, 10);
        instr(16'hF000, 0, 0, 100);
        instr(16'h4ABC, 5, 0, 0);
        instr(16'h6001, 3, 2, 0);
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            w = 16'($urandom);
            if (r < 70) begin
                w[15] = 1'b0;
                instr(w, $urandom_range(1, 12), 0, 0);
            end else if (r < 78) begin
                w[15:12] = 4'($urandom_range(8, 14));
                instr(w, 0, 0, 0);
            end else if (r < 83) begin
                w[15:12] = 4'hF;
                instr(w, 0, 0, $urandom_range(1, 20));
            end else if (r < 86) begin
                w[15] = 1'b0;
                instr(w, WD + 1, 0, $urandom_range(1, 5));
            end else if (r < 93) begin
                w[15] = 1'b0;
                instr(w, 12, $urandom_range(1, 10), 0);
            end else begin
                fetch(w, $urandom_range(1, MEM_LAT));
                do_rst();
            end
        end
        e = sched[sched.size()-1];
        add(16'h0, 0, e.fe, e.irl, e.ins, e.us, e.pci, e.bsy, e.hlt);
        sched[sched.size()-1].chk = 1'b0;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        build();
        foreach (sched[i]) begin
            @(posedge clk); #1;
            rst     = sched[i].rs;
            memData = sched[i].mem;
            done    = sched[i].dn;
`ifdef SINGLE_STEP_EN
            stepReq = sched[i].st;
`endif
            expq.push_back(sched[i]);
        end
        @(posedge clk);
        @(negedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                cyc++;
                if (e.chk) begin
                    chk("pcOutEN",     16'(pcOutEN),     16'(e.fe));
                    chk("memRdEN",     16'(memRdEN),     16'(e.fe));
                    chk("irLatch",     16'(irLatch),     16'(e.irl));
                    chk("instruction", instruction,      e.ins);
                    chk("unitSel",     16'(unitSel),     16'(e.us));
                    chk("pcInc",       16'(pcInc),       16'(e.pci));
                    chk("busy",        16'(busy),        16'(e.bsy));
                    chk("illegalOp",   16'(illegalOp),   16'(e.ill));
                    chk("wdogErr",     16'(wdogErr),     16'(e.wd));
                    chk("halted",      16'(halted),      16'(e.hlt));
                end
            end
        end
    end

endmodule
